// File: rtl/vga_capture.sv
// VGA timing capture: measures hsync/vsync against the configured mode, locks after one
// clean VS-aligned frame, then emits one registered pixel per active pix_en sample.
module vga_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned V_SYNC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  fb_x,
  output logic [7:0]  fb_y,
  output logic [11:0] pix_rgb,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  localparam logic [9:0] HStart   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HEnd     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VStart   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VEnd     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncW   = 10'(H_SYNC);
  localparam logic [9:0] CntMax   = 10'h3FF;
  localparam logic [1:0] ErrLine  = 2'b01;
  localparam logic [1:0] ErrFrame = 2'b10;
  localparam logic [1:0] ErrHsync = 2'b11;

  typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_e;

  state_e     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hsw_q, hsw_d;
  logic       prev_hs_q, prev_vs_q, vs_pend_q, vs_pend_d;

  logic       hs_fall, hs_rise, vs_fall, frame_start, checking;
  logic       err_hsw, err_frame, err_line, violation;
  logic [1:0] code;
  logic       active, valid_d;
  logic [9:0] x_d, y_d;

  assign hs_fall     = pix_en & prev_hs_q & ~vga_hs;
  assign hs_rise     = pix_en & ~prev_hs_q & vga_hs;
  assign vs_fall     = pix_en & prev_vs_q & ~vga_vs;
  // A VS fall coincident with the HS fall counts as the same frame start.
  assign frame_start = hs_fall & (vs_pend_q | vs_fall);

  // Timing is only judged once aligned; in SEARCH the history is untrusted.
  assign checking  = (state_q != StSearch);
  assign err_hsw   = checking & hs_rise & (hsw_q != HSyncW);
  assign err_frame = checking & frame_start & (vcnt_q != VLast);
  assign err_line  = checking & hs_fall & (hcnt_q != HLast);
  assign violation = err_hsw | err_frame | err_line;
  assign code      = err_hsw ? ErrHsync : (err_frame ? ErrFrame : ErrLine);

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    hsw_d     = hsw_q;
    vs_pend_d = vs_pend_q;
    if (pix_en) begin
      if (hs_fall) begin
        hcnt_d = '0;
        hsw_d  = 10'd1;
        if (frame_start)          vcnt_d = '0;
        else if (vcnt_q != CntMax) vcnt_d = vcnt_q + 10'd1;
      end else begin
        if (hcnt_q != CntMax)            hcnt_d = hcnt_q + 10'd1;
        if (!vga_hs && hsw_q != CntMax) hsw_d  = hsw_q + 10'd1;
      end
      if (frame_start)  vs_pend_d = 1'b0;
      else if (vs_fall) vs_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsw_q     <= '0;
      prev_hs_q <= 1'b1;
      prev_vs_q <= 1'b1;
      vs_pend_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsw_q     <= hsw_d;
      vs_pend_q <= vs_pend_d;
      if (pix_en) begin
        prev_hs_q <= vga_hs;
        prev_vs_q <= vga_vs;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StSearch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch: if (frame_start) state_d = StAlign;
      StAlign: begin
        if (violation)        state_d = StSearch;
        else if (frame_start) state_d = StLocked;
      end
      StLocked: if (violation) state_d = StSearch;
      default: state_d = StSearch;
    endcase
  end

  // Pixel position is that of the current sample, i.e. the post-update counters.
  always_comb begin
    active  = (hcnt_d >= HStart) && (hcnt_d < HEnd) && (vcnt_d >= VStart) && (vcnt_d < VEnd);
    valid_d = pix_en & active & (state_d == StLocked);
    x_d     = hcnt_d - HStart;
    y_d     = vcnt_d - VStart;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      fb_x      <= '0;
      fb_y      <= '0;
      pix_rgb   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      locked    <= (state_d == StLocked);
      pix_valid <= valid_d;
      err_pulse <= violation;
      if (violation) err_code <= code;
      if (valid_d) begin
        pix_x   <= x_d;
        pix_y   <= y_d;
        fb_x    <= x_d[9:2];
        fb_y    <= y_d[9:2];
        pix_rgb <= {vga_r, vga_g, vga_b};
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunken 16x12 timing (sync 3/2, back porch 2/2,
// active 8x6) so whole frames run quickly with pix_en every 4th clock.
module tb_vga_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        locked, pix_valid, err_pulse;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  fb_x, fb_y;
  logic [11:0] pix_rgb;
  logic [1:0]  err_code;

  vga_capture #(
    .H_ACTIVE(8), .H_BP(2), .H_TOTAL(16), .V_ACTIVE(6), .V_BP(2), .V_TOTAL(12),
    .H_SYNC(3), .V_SYNC(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .locked(locked), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .fb_x(fb_x), .fb_y(fb_y), .pix_rgb(pix_rgb),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_clks = 0;
  int unlocked_valid = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (err_pulse) err_clks++;
      if (pix_valid && !locked) unlocked_valid++;
    end
  end

  logic        obs_valid, obs_locked, obs_err;
  logic [1:0]  obs_code;
  logic [9:0]  obs_x, obs_y;
  logic [7:0]  obs_fbx, obs_fby;
  logic [11:0] obs_rgb;

  int          f_valid, f_bad, f_err, f_err_v, f_err_h;
  logic [1:0]  f_err_code;
  logic        f_err_locked, f_lock_first, f_lock_last;
  logic [11:0] f_first_rgb;
  logic [9:0]  f_first_x, f_first_y, f_last_x, f_last_y;
  logic [7:0]  f_last_fbx, f_last_fby;

  function automatic logic [11:0] rgb_of(input int h, input int v);
    if (h == 5 && v == 4) return 12'hF0A;
    return {4'(h), 4'(v), 4'h5};
  endfunction

  task automatic send_pix(input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    pix_en = 1'b1; vga_hs = hs; vga_vs = vs; {vga_r, vga_g, vga_b} = rgb;
    @(negedge clk);
    pix_en = 1'b0;
    obs_valid = pix_valid; obs_locked = locked; obs_err = err_pulse; obs_code = err_code;
    obs_x = pix_x; obs_y = pix_y; obs_fbx = fb_x; obs_fby = fb_y; obs_rgb = pix_rgb;
    repeat (2) @(negedge clk);
  endtask

  // Lines v0..v1-1 of a vlines-line frame; line short_v has 15 pixels, line hsw_v a 2-wide hsync.
  task automatic send_frame(input int vlines, input int v0, input int v1, input int short_v,
                            input int hsw_v);
    int len, hw;
    logic hs, vs;
    f_valid = 0; f_bad = 0; f_err = 0; f_err_v = -1; f_err_h = -1;
    f_err_code = 2'b00; f_err_locked = 1'bx;
    f_first_rgb = '1; f_first_x = '1; f_first_y = '1;
    f_last_x = '1; f_last_y = '1; f_last_fbx = '1; f_last_fby = '1;
    for (int v = v0; v < v1; v++) begin
      len = (v == short_v) ? 15 : 16;
      hw  = (v == hsw_v) ? 2 : 3;
      for (int h = 0; h < len; h++) begin
        hs = (h >= hw) ? 1'b1 : 1'b0;
        vs = (v < 2 || (v == vlines - 1 && h == len - 1)) ? 1'b0 : 1'b1;
        send_pix(hs, vs, rgb_of(h, v));
        if (v == v0 && h == 0) f_lock_first = obs_locked;
        f_lock_last = obs_locked;
        if (obs_err) begin
          f_err++; f_err_v = v; f_err_h = h; f_err_code = obs_code; f_err_locked = obs_locked;
        end
        if (obs_valid) begin
          f_valid++;
          if (h < 5 || h >= 13 || v < 4 || v >= 10 || obs_x !== 10'(h - 5) ||
              obs_y !== 10'(v - 4) || obs_fbx !== 8'((h - 5) / 4) ||
              obs_fby !== 8'((v - 4) / 4) || obs_rgb !== rgb_of(h, v)) f_bad++;
          if (h == 5 && v == 4) begin
            f_first_rgb = obs_rgb; f_first_x = obs_x; f_first_y = obs_y;
          end
          if (h == 12 && v == 9) begin
            f_last_x = obs_x; f_last_y = obs_y; f_last_fbx = obs_fbx; f_last_fby = obs_fby;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
    checks++; if (pix_x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", pix_x); end
    checks++; if (pix_y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", pix_y); end
    checks++; if (fb_x !== 8'd0 || fb_y !== 8'd0) begin errors++; $display("FAIL reset_fb: got %0d/%0d want 0/0", fb_x, fb_y); end
    checks++; if (pix_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", pix_rgb); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    send_pix(1'b1, 1'b0, 12'h000);
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_last !== 1'b0) begin errors++; $display("FAIL lock_align_locked: got %b want 0", f_lock_last); end
    checks++; if (f_valid !== 0) begin errors++; $display("FAIL lock_align_valid: got %0d want 0", f_valid); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_first !== 1'b1) begin errors++; $display("FAIL lock_frame2_start: got %b want 1", f_lock_first); end
    checks++; if (f_valid !== 48) begin errors++; $display("FAIL lock_valid_count: got %0d want 48", f_valid); end
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL lock_pixel_data: got %0d bad want 0", f_bad); end
    checks++; if (f_first_rgb !== 12'hF0A) begin errors++; $display("FAIL first_rgb: got %h want f0a", f_first_rgb); end
    checks++; if (f_first_x !== 10'd0 || f_first_y !== 10'd0) begin errors++; $display("FAIL first_xy: got %0d,%0d want 0,0", f_first_x, f_first_y); end
    checks++; if (f_last_x !== 10'd7 || f_last_y !== 10'd5) begin errors++; $display("FAIL last_xy: got %0d,%0d want 7,5", f_last_x, f_last_y); end
    checks++; if (f_last_fbx !== 8'd1 || f_last_fby !== 8'd1) begin errors++; $display("FAIL last_fb: got %0d,%0d want 1,1", f_last_fbx, f_last_fby); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_valid !== 48) begin errors++; $display("FAIL lock_frame3_count: got %0d want 48", f_valid); end
    checks++; if (err_clks !== 0) begin errors++; $display("FAIL lock_no_err: got %0d err clks want 0", err_clks); end
  endtask

  task automatic test_short_line;
    int e0 = err_clks;
    send_frame(12, 0, 12, 5, -1);
    checks++; if (f_err !== 1 || f_err_v !== 6 || f_err_h !== 0) begin errors++; $display("FAIL short_err_pos: got n=%0d v=%0d h=%0d want 1,6,0", f_err, f_err_v, f_err_h); end
    checks++; if (f_err_code !== 2'b01) begin errors++; $display("FAIL short_err_code: got %b want 01", f_err_code); end
    checks++; if (f_err_locked !== 1'b0) begin errors++; $display("FAIL short_unlock: got %b want 0", f_err_locked); end
    checks++; if (f_valid !== 16) begin errors++; $display("FAIL short_valid: got %0d want 16", f_valid); end
    checks++; if (err_clks - e0 !== 1) begin errors++; $display("FAIL short_pulse_width: got %0d clks want 1", err_clks - e0); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_last !== 1'b0 || f_valid !== 0) begin errors++; $display("FAIL short_realign: got lock=%b valid=%0d want 0,0", f_lock_last, f_valid); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_first !== 1'b1 || f_valid !== 48) begin errors++; $display("FAIL short_relock: got lock=%b valid=%0d want 1,48", f_lock_first, f_valid); end
  endtask

  task automatic test_hsync_width;
    send_frame(12, 0, 12, -1, 3);
    checks++; if (f_err !== 1 || f_err_v !== 3 || f_err_h !== 2) begin errors++; $display("FAIL hsw_err_pos: got n=%0d v=%0d h=%0d want 1,3,2", f_err, f_err_v, f_err_h); end
    checks++; if (f_err_code !== 2'b11) begin errors++; $display("FAIL hsw_err_code: got %b want 11", f_err_code); end
    checks++; if (f_valid !== 0 || f_lock_last !== 1'b0) begin errors++; $display("FAIL hsw_unlock: got valid=%0d lock=%b want 0,0", f_valid, f_lock_last); end
    send_frame(12, 0, 12, -1, -1);
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_valid !== 48) begin errors++; $display("FAIL hsw_relock: got %0d want 48", f_valid); end
  endtask

  task automatic test_frame_length;
    // 11-line frame whose last line is also short: frame and line errors coincide.
    send_frame(11, 0, 11, 10, -1);
    checks++; if (f_err !== 0 || f_valid !== 48) begin errors++; $display("FAIL flen_body: got err=%0d valid=%0d want 0,48", f_err, f_valid); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_err !== 1 || f_err_v !== 0 || f_err_h !== 0) begin errors++; $display("FAIL flen_err_pos: got n=%0d v=%0d h=%0d want 1,0,0", f_err, f_err_v, f_err_h); end
    checks++; if (f_err_code !== 2'b10) begin errors++; $display("FAIL flen_err_code: got %b want 10", f_err_code); end
    checks++; if (f_valid !== 0 || f_lock_first !== 1'b0) begin errors++; $display("FAIL flen_unlock: got valid=%0d lock=%b want 0,0", f_valid, f_lock_first); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_last !== 1'b0) begin errors++; $display("FAIL flen_search: got lock=%b want 0", f_lock_last); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_lock_first !== 1'b1 || f_valid !== 48) begin errors++; $display("FAIL flen_relock: got lock=%b valid=%0d want 1,48", f_lock_first, f_valid); end
  endtask

  task automatic test_midframe_reset;
    send_frame(12, 0, 6, -1, -1);
    for (int h = 0; h < 8; h++) send_pix((h >= 3) ? 1'b1 : 1'b0, 1'b1, rgb_of(h, 6));
    @(negedge clk);
    pix_en = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; {vga_r, vga_g, vga_b} = rgb_of(8, 6);
    @(negedge clk);
    pix_en = 1'b0;
    checks++; if (pix_valid !== 1'b1 || pix_x !== 10'd3 || pix_y !== 10'd2) begin errors++; $display("FAIL mid_pre: got v=%b x=%0d y=%0d want 1,3,2", pix_valid, pix_x, pix_y); end
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL mid_pre_code: got %b want 10", err_code); end
    #1 rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL mid_async_flags: got lock=%b valid=%b want 0,0", locked, pix_valid); end
    checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL mid_async_xy: got %0d,%0d want 0,0", pix_x, pix_y); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL mid_async_code: got %b want 00", err_code); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(12, 7, 12, -1, -1);
    checks++; if (f_valid !== 0 || f_lock_last !== 1'b0) begin errors++; $display("FAIL mid_partial: got valid=%0d lock=%b want 0,0", f_valid, f_lock_last); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_valid !== 0 || f_lock_last !== 1'b0) begin errors++; $display("FAIL mid_align: got valid=%0d lock=%b want 0,0", f_valid, f_lock_last); end
    send_frame(12, 0, 12, -1, -1);
    checks++; if (f_valid !== 48 || f_bad !== 0) begin errors++; $display("FAIL mid_relock: got valid=%0d bad=%0d want 48,0", f_valid, f_bad); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_hsync_width();
    test_frame_length();
    test_midframe_reset();
    checks++; if (unlocked_valid !== 0) begin errors++; $display("FAIL valid_while_unlocked: got %0d want 0", unlocked_valid); end
    checks++; if (err_clks !== 3) begin errors++; $display("FAIL total_err_clks: got %0d want 3", err_clks); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_BP 48 back-porch pixels; H_TOTAL 800 pixels/line; V_ACTIVE 480 visible lines; V_BP 33 back-porch lines; V_TOTAL 525 lines/frame; H_SYNC 96 hsync width; V_SYNC 2 vsync width (lines).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel strobe, 1 clk per pixel period.
- vga_hs  in  1  horizontal sync, active low.
- vga_vs  in  1  vertical sync, active low.
- vga_r / vga_g / vga_b  in  4 each  colour inputs.
- locked  out  1  timing verified, outputs valid.
- pix_valid  out  1  captured pixel is in the active area.
- pix_x  out  10  active column, 0..H_ACTIVE-1.
- pix_y  out  10  active row, 0..V_ACTIVE-1.
- fb_x  out  8  pix_x/4.
- fb_y  out  8  pix_y/4.
- pix_rgb  out  12  {r,g,b} of the captured pixel.
- err_pulse  out  1  one-clk pulse on a timing violation.
- err_code  out  2  00 none, 01 bad line length, 10 bad frame length, 11 hsync width.

Function
REQ-003 SHALL sample vga_hs, vga_vs and RGB only on clk edges where pix_en=1; all internal state SHALL hold when pix_en=0.
REQ-004 SHALL detect an HS fall as prev_hs=1 and vga_hs=0 on a pix_en sample; hcnt SHALL load 0 on that sample and otherwise increment, saturating at 1023.
REQ-005 SHALL latch a vs_pending flag on a VS fall; at the next HS fall, vcnt SHALL load 0 and vs_pending SHALL clear; at any other HS fall vcnt SHALL increment, saturating at 1023.
REQ-006 SHALL measure the hsync low width in pix_en samples; at the HS rise, a width other than H_SYNC SHALL be a violation with code 11.
REQ-007 SHALL implement a three-state FSM:
- SEARCH -> ALIGN on the first HS fall with vs_pending=1.
- ALIGN -> LOCKED at the next frame start when no violation occurred during the frame.
- ALIGN or LOCKED -> SEARCH on any violation.
REQ-008 In ALIGN and LOCKED, an HS fall with previous hcnt != H_TOTAL-1 SHALL be a violation with code 01.
REQ-009 In ALIGN and LOCKED, a frame start with previous vcnt != V_TOTAL-1 SHALL be a violation with code 10.
REQ-010 On a violation, err_pulse SHALL be 1 for exactly one clk and err_code SHALL hold the code until the next violation.
- If violations coincide, priority SHALL be 11 > 10 > 01.
REQ-011 The active area SHALL be H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE (144..783) and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE (35..514).
REQ-012 pix_valid SHALL be 1 for one clk, registered 1 clk after a pix_en sample that is in the active area while in LOCKED.
- pix_x = hcnt-144, pix_y = vcnt-35.
- fb_x = pix_x[9:2], fb_y = pix_y[9:2].
- pix_rgb = RGB from that same sample.
REQ-013 locked SHALL equal (state==LOCKED), registered; pix_valid SHALL never be 1 while locked=0.
REQ-014 When leaving LOCKED on a violation, locked and pix_valid SHALL be 0 from the next clk.

Reset
REQ-015 While rst=1, asynchronously:
- state=SEARCH;
- hcnt, vcnt, hsync-width counter = 0;
- prev_hs=1, prev_vs=1, vs_pending=0;
- all outputs = 0, including err_code=00.
REQ-016 After rst deasserts, the block SHALL need a complete VS-aligned frame before locked=1; reset mid-frame SHALL discard all partial measurements.

Verification
REQ-017 Clean 640x480 source with pix_en every 4th clk -> locked=1 at the start of the 2nd frame after the first VS; exactly 307200 pix_valid pulses per locked frame; err_pulse never asserted.
REQ-018 Locked, pixel at hcnt=144, vcnt=35 with RGB=0xF0A -> next clk: pix_valid=1, pix_x=0, pix_y=0, fb_x=0, fb_y=0, pix_rgb=0xF0A; at hcnt=783, vcnt=514 -> pix_x=639, pix_y=479, fb_x=159, fb_y=119.
REQ-019 Locked, one line shortened to 799 pixels -> err_pulse=1 for one clk with err_code=01 at the next HS fall; locked=0 on the next clk; relock after one clean frame.
REQ-020 Locked, hsync width 95 -> err_code=11 at the HS rise; if a line-length error occurs in the same sample, err_code=11 is reported.
REQ-021 Frame of 524 lines -> err_code=10 at the frame start; FSM returns to SEARCH.
REQ-022 rst asserted mid-frame while locked -> locked, pix_valid, err_code, pix_x, pix_y all 0 immediately, without waiting for clk; after release, no pix_valid until a full frame re-verifies.
